ps2_kbd_matrix: RTL and testbench



---
 rtl/ps2_kbd_matrix.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_kbd_matrix.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_matrix.sv
// ============================================================================
// ps2_kbd_matrix -- PS/2 keyboard receiver driving an emulated C64 8x8 key
// matrix scanned by CIA1, plus the RESTORE level.
// Optional macro KBD_ERR_CNT_EN adds the saturating err_cnt_o error counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_kbd_matrix #(
    parameter int TIMEOUT_CYCLES = 8000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] row_i,
    output logic [7:0] col_o,
`ifdef KBD_ERR_CNT_EN
    output logic [7:0] err_cnt_o,
`endif
    output logic       restore_o
);

    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;
    localparam logic [1:0] c_ST_STOP   = 2'd3;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    logic                   w_strobe;
    logic                   w_bit;

    logic [1:0]        r_state;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic [c_TO_W-1:0] r_to_cnt;
    logic              w_timeout;
    logic              w_frame_ok;
    logic              r_byte_valid;
    logic [7:0]        r_byte;

    logic        r_brk;
    logic        r_ext;
    logic [63:0] r_key;
    logic [6:0]  w_map;
    logic [7:0]  w_col;

    // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_strobe   = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
    assign w_bit      = r_dat_sync[SYNC_STAGES-1];
    assign w_timeout  = (r_state != c_ST_IDLE) && !w_strobe &&
                        (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
    assign w_frame_ok = w_bit & (^{r_shift, r_parity});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'd0;
            r_parity     <= 1'b0;
            r_to_cnt     <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= 8'd0;
        end else begin
            r_byte_valid <= 1'b0;
            if (r_state == c_ST_IDLE) begin
                r_to_cnt <= '0;
                if (w_strobe && !w_bit) begin
                    r_state   <= c_ST_DATA;
                    r_bit_cnt <= 3'd0;
                end
            end else if (w_timeout) begin
                r_state  <= c_ST_IDLE;
                r_to_cnt <= '0;
            end else if (w_strobe) begin
                r_to_cnt <= '0;
                if (r_state == c_ST_DATA) begin
                    r_shift   <= {w_bit, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) r_state <= c_ST_PARITY;
                end else if (r_state == c_ST_PARITY) begin
                    r_parity <= w_bit;
                    r_state  <= c_ST_STOP;
                end else begin
                    if (w_frame_ok) begin
                        r_byte_valid <= 1'b1;
                        r_byte       <= r_shift;
                    end
                    r_state <= c_ST_IDLE;
                end
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    // Encoding: {hit, row[2:0], col[2:0]}; key index is {row, col}.
    always_comb begin
        w_map = 7'o000;
        case ({r_ext, r_byte})
            9'h066: w_map = 7'o100;  9'h05A: w_map = 7'o101;
            9'h005: w_map = 7'o104;  9'h16B: w_map = 7'o102;
            9'h026: w_map = 7'o110;  9'h01D: w_map = 7'o111;
            9'h01C: w_map = 7'o112;  9'h025: w_map = 7'o113;
            9'h01A: w_map = 7'o114;  9'h01B: w_map = 7'o115;
            9'h024: w_map = 7'o116;  9'h012: w_map = 7'o117;
            9'h02E: w_map = 7'o120;  9'h02D: w_map = 7'o121;
            9'h023: w_map = 7'o122;  9'h036: w_map = 7'o123;
            9'h021: w_map = 7'o124;  9'h02B: w_map = 7'o125;
            9'h02C: w_map = 7'o126;  9'h022: w_map = 7'o127;
            9'h03D: w_map = 7'o130;  9'h035: w_map = 7'o131;
            9'h034: w_map = 7'o132;  9'h03E: w_map = 7'o133;
            9'h032: w_map = 7'o134;  9'h033: w_map = 7'o135;
            9'h03C: w_map = 7'o136;  9'h02A: w_map = 7'o137;
            9'h046: w_map = 7'o140;  9'h043: w_map = 7'o141;
            9'h03B: w_map = 7'o142;  9'h045: w_map = 7'o143;
            9'h03A: w_map = 7'o144;  9'h042: w_map = 7'o145;
            9'h044: w_map = 7'o146;  9'h031: w_map = 7'o147;
            9'h04D: w_map = 7'o151;  9'h04B: w_map = 7'o152;
            9'h059: w_map = 7'o164;
            9'h016: w_map = 7'o170;  9'h014: w_map = 7'o172;
            9'h01E: w_map = 7'o173;  9'h029: w_map = 7'o174;
            9'h015: w_map = 7'o176;  9'h076: w_map = 7'o177;
            default: w_map = 7'o000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key     <= 64'd0;
            restore_o <= 1'b0;
            r_brk     <= 1'b0;
            r_ext     <= 1'b0;
        end else if (r_byte_valid) begin
            if (r_byte == 8'hF0) begin
                r_brk <= 1'b1;
            end else if (r_byte == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (r_byte == 8'hAA || r_byte == 8'h00 || r_byte == 8'hFF) begin
                r_key     <= 64'd0;
                restore_o <= 1'b0;
                r_brk     <= 1'b0;
                r_ext     <= 1'b0;
            end else begin
                if (r_ext && r_byte == 8'h7D) begin
                    restore_o <= !r_brk;
                end else if (w_map[6]) begin
                    r_key[w_map[5:0]] <= !r_brk;
                end
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end
        end
    end

    always_comb begin
        w_col = 8'hFF;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (!row_i[r] && r_key[r*8 + c]) w_col[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) col_o <= 8'hFF;
        else       col_o <= w_col;
    end

`ifdef KBD_ERR_CNT_EN
    logic       w_err;
    logic [7:0] r_err_cnt;

    assign w_err = ((r_state == c_ST_STOP) && w_strobe && !w_frame_ok) || w_timeout;

    always_ff @(posedge clk) begin
        if (reset)                           r_err_cnt <= 8'd0;
        else if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_cnt_o = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps2_kbd_matrix.sv
// ============================================================================
// tb_ps2_kbd_matrix -- self-checking bench for ps2_kbd_matrix.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ps2_kbd_matrix;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] row_i = 8'hFF;
    logic [7:0] col_o;
    logic       restore_o;
`ifdef KBD_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    ps2_kbd_matrix dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .row_i     (row_i),
        .col_o     (col_o),
`ifdef KBD_ERR_CNT_EN
        .err_cnt_o (err_cnt),
`endif
        .restore_o (restore_o)
    );

    always #5 clk = ~clk;

    // Sends the first nbits bits of a frame (11 = complete frame).
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (8) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (8) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic scan(input logic [7:0] rows);
        row_i = rows;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        row_i = 8'h00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        exp_q.push_back(8'hFF);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (col_o !== exp_v) begin
            n_errors++;
            $display("FAIL reset_col: got %h expected %h", col_o, exp_v);
        end
        n_checks++;
        if (restore_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_restore: got %b expected 0", restore_o);
        end
`ifdef KBD_ERR_CNT_EN
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt);
        end
`endif
        reset = 1'b0;
        row_i = 8'hFF;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_single_key;
        send_frame(8'h1C, 1'b0, 11);
        exp_q.push_back(8'hFB);
        scan(8'hFD);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (col_o !== exp_v) begin
            n_errors++;
            $display("FAIL a_row1: got %h expected %h", col_o, exp_v);
        end
        exp_q.push_back(8'hFF);
        scan(8'hFE);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (col_o !== exp_v) begin
            n_errors++;
            $display("FAIL a_row0: got %h expected %h", col_o, exp_v);
        end
    endtask

    task automatic test_break;
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 11);
        exp_q.push_back(8'hFF);
        scan(8'h00);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (col_o !== exp_v) begin
            n_errors++;
            $display("FAIL a_release: got %h expected %h", col_o, exp_v);
        end
        // A stuck break flag would turn this make code into a release.
        send_frame(8'h1C, 1'b0, 11);
        exp_q.push_back(8'hFB);
        scan(8'h00);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (col_o !== exp_v) begin
            n_errors++;
            $display("FAIL break_cleared: got %h expected %h", col_o, exp_v);
        end
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 11);
    endtask

    task automatic test_multi_row;
        send_frame(8'h29, 1'b0, 11);
        send_frame(8'h12, 1'b0, 11);
        exp_q.push_back(8'h6F);
        scan(8'h7D);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (col_o !== exp_v) begin
            n_errors++;
            $display("FAIL space_lshift: got %h expected %h", col_o, exp_v);
        end
        exp_q.push_back(8'hFF);
        scan(8'hFF);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (col_o !== exp_v) begin
            n_errors++;
            $display("FAIL no_rows: got %h expected %h", col_o, exp_v);
        end
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h29, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h12, 1'b0, 11);
    endtask

    task automatic test_errors;
        send_frame(8'h29, 1'b1, 11);
        send_frame(8'h29, 1'b0, 5);
        repeat (8050) @(posedge clk);
        exp_q.push_back(8'hFF);
        scan(8'h7F);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (col_o !== exp_v) begin
            n_errors++;
            $display("FAIL err_unchanged: got %h expected %h", col_o, exp_v);
        end
        send_frame(8'h29, 1'b0, 11);
        exp_q.push_back(8'hEF);
        scan(8'h7F);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (col_o !== exp_v) begin
            n_errors++;
            $display("FAIL err_recover: got %h expected %h", col_o, exp_v);
        end
`ifdef KBD_ERR_CNT_EN
        exp_q.push_back(8'd2);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (err_cnt !== exp_v) begin
            n_errors++;
            $display("FAIL err_cnt: got %0d expected %0d", err_cnt, exp_v);
        end
`endif
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h29, 1'b0, 11);
    endtask

    task automatic test_restore_bat;
        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'h7D, 1'b0, 11);
        @(negedge clk);
        n_checks++;
        if (restore_o !== 1'b1) begin
            n_errors++;
            $display("FAIL restore_press: got %b expected 1", restore_o);
        end
        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h7D, 1'b0, 11);
        @(negedge clk);
        n_checks++;
        if (restore_o !== 1'b0) begin
            n_errors++;
            $display("FAIL restore_release: got %b expected 0", restore_o);
        end
        send_frame(8'h5A, 1'b0, 11);
        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'h7D, 1'b0, 11);
        exp_q.push_back(8'hFD);
        scan(8'hFE);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (col_o !== exp_v) begin
            n_errors++;
            $display("FAIL return_held: got %h expected %h", col_o, exp_v);
        end
        send_frame(8'hAA, 1'b0, 11);
        exp_q.push_back(8'hFF);
        scan(8'h00);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (col_o !== exp_v) begin
            n_errors++;
            $display("FAIL bat_release: got %h expected %h", col_o, exp_v);
        end
        n_checks++;
        if (restore_o !== 1'b0) begin
            n_errors++;
            $display("FAIL bat_restore: got %b expected 0", restore_o);
        end
    endtask

    task automatic test_reset_mid_frame;
        send_frame(8'h5A, 1'b0, 6);
        @(posedge clk);
        reset = 1'b1;
        @(posedge clk);
        reset = 1'b0;
        exp_q.push_back(8'hFF);
        scan(8'hFE);
        repeat (40) @(posedge clk);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (col_o !== exp_v) begin
            n_errors++;
            $display("FAIL reset_mid: got %h expected %h", col_o, exp_v);
        end
        send_frame(8'h5A, 1'b0, 11);
        exp_q.push_back(8'hFD);
        scan(8'hFE);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (col_o !== exp_v) begin
            n_errors++;
            $display("FAIL after_reset: got %h expected %h", col_o, exp_v);
        end
    endtask

    initial begin
        test_reset;
        test_single_key;
        test_break;
        test_multi_row;
        test_errors;
        test_restore_bat;
        test_reset_mid_frame;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
